// File: rtl/pe_mp_pkg.sv
// Shared types and helpers for the multi-precision multi-lane PE.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pe_mp_pkg;

    typedef enum logic [1:0] {
        MODE_8X8   = 2'd0,
        MODE_8X16  = 2'd1,
        MODE_16X16 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Sub-product index bits: bit 0 picks the upper weight word (B1),
    // bit 1 picks the upper A half (Ahi). Shift follows from the same bits.
    localparam int SEL_B1_BIT  = 0;
    localparam int SEL_AHI_BIT = 1;

    // Number of sub-product steps needed per operand beat.
    function automatic logic [2:0] steps_for(input mode_e m);
        case (m)
            MODE_8X16:  return 3'd2;
            MODE_16X16: return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/pe_mp_lane.sv
// One PE lane: piece mux, signed-configurable A_W x B_W multiply, shift, accumulate.
// Latency: one sub-product accumulated per enabled cycle; result register loads on fin.
// Backpressure: none locally; the top level gates acc_en/fin.
module pe_mp_lane
    import pe_mp_pkg::*;
#(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int RES_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*A_W-1:0]     a_in,
    input  logic                 a_load,
    input  logic                 use_reg,
    input  logic [1:0]           idx,
    input  logic [1:0]           mode,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [B_W-1:0]       b0,
    input  logic [B_W-1:0]       b1,
    input  logic                 acc_clr,
    input  logic                 acc_en,
    input  logic                 fin,
    output logic [RES_W-1:0]     res
);

    localparam int PW = A_W + B_W + 2;

    logic [2*A_W-1:0]      a_reg;
    logic [2*A_W-1:0]      a_cur;
    logic [A_W-1:0]        a_pc;
    logic [B_W-1:0]        b_pc;
    logic                  a_sgn;
    logic                  b_sgn;
    logic signed [A_W:0]   a_ext;
    logic signed [B_W:0]   b_ext;
    logic signed [PW-1:0]  a_w;
    logic signed [PW-1:0]  b_w;
    logic signed [PW-1:0]  prod;
    logic [RES_W-1:0]      prod_x;
    logic [RES_W-1:0]      term;
    logic [RES_W-1:0]      acc;
    logic [RES_W-1:0]      acc_nxt;

    // Select pieces, apply per-piece signedness, multiply, align and add.
    always_comb begin
        a_cur  = use_reg ? a_reg : a_in;
        a_pc   = idx[SEL_AHI_BIT] ? a_cur[2*A_W-1:A_W] : a_cur[A_W-1:0];
        b_pc   = idx[SEL_B1_BIT] ? b1 : b0;
        // Only the top piece of each operand carries the sign.
        a_sgn  = sign_a & (idx[SEL_AHI_BIT] == (mode == MODE_16X16));
        b_sgn  = sign_b & (idx[SEL_B1_BIT] == (mode != MODE_8X8));
        a_ext  = $signed({a_sgn & a_pc[A_W-1], a_pc});
        b_ext  = $signed({b_sgn & b_pc[B_W-1], b_pc});
        a_w    = PW'(a_ext);
        b_w    = PW'(b_ext);
        prod   = a_w * b_w;
        prod_x = RES_W'(prod);
        case (idx)
            2'd0:    term = prod_x;
            2'd1:    term = prod_x << B_W;
            2'd2:    term = prod_x << A_W;
            default: term = prod_x << (A_W + B_W);
        endcase
        acc_nxt = acc + term;
    end

    // Hold the lane operand for the remaining steps of a multi-step beat.
    always_ff @(posedge clk) begin
        if (reset)
            a_reg <= '0;
        else if (a_load)
            a_reg <= a_in;
    end

    // Accumulate; on the final step publish acc+product and restart from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            res <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_en) begin
            if (fin) begin
                res <= acc_nxt;
                acc <= '0;
            end else begin
                acc <= acc_nxt;
            end
        end
    end

endmodule

// File: rtl/pe_mp_lanes.sv
// Multi-lane multi-precision MAC PE with shared streamed weight memory.
// Latency: out_valid the cycle after the last sub-step of beat acc_len (mode0/acc_len=1: 1 cycle).
// Backpressure: a pending unaccepted result blocks in_ready and the next result's final step.
module pe_mp_lanes
    import pe_mp_pkg::*;
#(
    parameter int LANES = 2,
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int B_D   = 4,
    parameter int RES_W = 32,
    parameter int LEN_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [LEN_W-1:0]            acc_len,
    input  logic                        sign_a,
    input  logic                        sign_b,
    output logic                        busy,
    input  logic                        w_wr_en,
    input  logic [$clog2(B_D)-1:0]      w_wr_addr,
    input  logic [B_W-1:0]              w_wr_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*2*A_W-1:0]      in_a,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*RES_W-1:0]      out_res
);

    localparam int PTR_W = $clog2(B_D);

    state_e             state;
    mode_e              mode_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic [2:0]         step_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic [B_W-1:0]     wmem [B_D];

    logic [B_W-1:0]     b0;
    logic [B_W-1:0]     b1;
    logic [2:0]         n_steps;
    logic               stall_out;
    logic               accept;
    logic               last_step;
    logic               do_acc;
    logic               beat_done;
    logic               job_done;
    logic               acc_clr;
    logic [1:0]         idx;
    logic [PTR_W-1:0]   ptr_adv;

    // Handshake and sequencing decode from the current state.
    always_comb begin
        n_steps   = steps_for(mode_q);
        stall_out = out_valid && !out_ready;
        in_ready  = (state == RUN) && !stall_out;
        accept    = in_valid && in_ready;
        last_step = (state == STEP) && (step_q == n_steps - 3'd1);
        do_acc    = accept || ((state == STEP) && !(last_step && stall_out));
        beat_done = (accept && (n_steps == 3'd1)) || (last_step && !stall_out);
        job_done  = beat_done && (beat_q == len_q - LEN_W'(1));
        idx       = (state == STEP) ? step_q[1:0] : 2'd0;
        acc_clr   = (state == IDLE) && start;
        ptr_adv   = (mode_q == MODE_8X8) ? PTR_W'(1) : PTR_W'(2);
        b0        = wmem[ptr_q];
        b1        = wmem[ptr_q + PTR_W'(1)];
        busy      = (state != IDLE);
    end

    // Weight memory: plain storage, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            wmem[w_wr_addr] <= w_wr_data;
    end

    // Job FSM, beat/step counters, weight pointer and result valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= MODE_8X8;
            len_q     <= '0;
            beat_q    <= '0;
            step_q    <= '0;
            ptr_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (job_done)
                out_valid <= 1'b1;
            if (beat_done) begin
                ptr_q  <= ptr_q + ptr_adv;
                beat_q <= job_done ? '0 : beat_q + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        mode_q   <= (mode == 2'd3) ? MODE_8X8 : mode_e'(mode);
                        len_q    <= (acc_len == '0) ? LEN_W'(1) : acc_len;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        ptr_q    <= '0;
                        beat_q   <= '0;
                        step_q   <= '0;
                    end
                end
                RUN: begin
                    if (accept && (n_steps != 3'd1)) begin
                        state  <= STEP;
                        step_q <= 3'd1;
                    end else if (job_done) begin
                        state <= start ? RUN : HOLD;
                    end
                end
                STEP: begin
                    if (last_step) begin
                        if (!stall_out) begin
                            step_q <= '0;
                            state  <= (job_done && !start) ? HOLD : RUN;
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (!stall_out && !start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_mp_lane #(
            .A_W   (A_W),
            .B_W   (B_W),
            .RES_W (RES_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .a_in    (in_a[i*2*A_W +: 2*A_W]),
            .a_load  (accept),
            .use_reg (state == STEP),
            .idx     (idx),
            .mode    (mode_q),
            .sign_a  (sign_a_q),
            .sign_b  (sign_b_q),
            .b0      (b0),
            .b1      (b1),
            .acc_clr (acc_clr),
            .acc_en  (do_acc),
            .fin     (job_done),
            .res     (out_res[i*RES_W +: RES_W])
        );
    end

endmodule

// File: tb/tb_pe_mp_lanes.sv
// Directed bench for pe_mp_lanes: precision modes, signedness, pointer wrap,
// result backpressure, mid-job reset and back-to-back results.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_pe_mp_lanes;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  acc_len;
    logic        sign_a;
    logic        sign_b;
    logic        busy;
    logic        w_wr_en;
    logic [1:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic [31:0] res0;
    logic [31:0] res1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign res0 = out_res[31:0];
    assign res1 = out_res[63:32];

    pe_mp_lanes #(
        .LANES(2), .A_W(8), .B_W(8), .B_D(4), .RES_W(32), .LEN_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .acc_len   (acc_len),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .busy      (busy),
        .w_wr_en   (w_wr_en),
        .w_wr_addr (w_wr_addr),
        .w_wr_data (w_wr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_w(input logic [1:0] addr, input logic [7:0] data);
        w_wr_en   = 1'b1;
        w_wr_addr = addr;
        w_wr_data = data;
        tick();
        w_wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present a job config with start high for one edge; start stays high.
    task automatic launch(input logic [1:0] m, input logic [7:0] len,
                          input logic sa, input logic sb);
        mode    = m;
        acc_len = len;
        sign_a  = sa;
        sign_b  = sb;
        start   = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_vec++; if (out_res !== 64'd0) begin n_err++; $display("FAIL rst_out_res got=%h want=0", out_res); end
    endtask

    task automatic test_mode0_signed();
        wr_w(2'd0, 8'd3);
        wr_w(2'd1, 8'd5);
        wr_w(2'd2, 8'd7);
        wr_w(2'd3, 8'hFE);
        launch(2'd0, 8'd2, 1'b1, 1'b1);
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL m0_busy got=%b want=1", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL m0_in_ready got=%b want=1", in_ready); end
        in_valid = 1'b1;
        in_a = {16'hFFFF, 16'h0002};
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL m0_early_valid got=%b want=0", out_valid); end
        in_a = {16'hFFFF, 16'h0004};
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m0_valid got=%b want=1", out_valid); end
        n_vec++; if (res0 !== 32'd26) begin n_err++; $display("FAIL m0_lane0 got=%h want=%h", res0, 32'd26); end
        n_vec++; if (res1 !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL m0_lane1 got=%h want=%h", res1, 32'hFFFF_FFF8); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m0_idle got=%b want=0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL m0_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_mode2_unsigned();
        wr_w(2'd0, 8'h78);
        wr_w(2'd1, 8'h56);
        launch(2'd2, 8'd1, 1'b0, 1'b0);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = {16'h0001, 16'h1234};
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL m2u_step%0d_in_ready got=%b want=0", k, in_ready); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL m2u_step%0d_valid got=%b want=0", k, out_valid); end
            tick();
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m2u_valid got=%b want=1", out_valid); end
        n_vec++; if (res0 !== 32'h0626_0060) begin n_err++; $display("FAIL m2u_lane0 got=%h want=%h", res0, 32'h0626_0060); end
        n_vec++; if (res1 !== 32'h0000_5678) begin n_err++; $display("FAIL m2u_lane1 got=%h want=%h", res1, 32'h0000_5678); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m2u_idle got=%b want=0", busy); end
    endtask

    task automatic test_mode2_signed();
        wr_w(2'd0, 8'h03);
        wr_w(2'd1, 8'h00);
        launch(2'd2, 8'd1, 1'b1, 1'b1);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = {16'h0002, 16'hFFFE};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m2s_valid got=%b want=1", out_valid); end
        n_vec++; if (res0 !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL m2s_lane0 got=%h want=%h", res0, 32'hFFFF_FFFA); end
        n_vec++; if (res1 !== 32'd6) begin n_err++; $display("FAIL m2s_lane1 got=%h want=%h", res1, 32'd6); end
        tick();
    endtask

    task automatic test_mode1_wrap();
        logic [31:0] exp0 [3];
        logic [31:0] exp1 [3];
        exp0[0] = 32'h2211; exp0[1] = 32'h4433; exp0[2] = 32'h2211;
        exp1[0] = 32'h4422; exp1[1] = 32'h8866; exp1[2] = 32'h4422;
        wr_w(2'd0, 8'h11);
        wr_w(2'd1, 8'h22);
        wr_w(2'd2, 8'h33);
        wr_w(2'd3, 8'h44);
        launch(2'd1, 8'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) start = 1'b0;
            in_valid = 1'b1;
            in_a = {16'h7702, 16'h0001};
            tick();
            in_valid = 1'b0;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL m1_beat%0d_in_ready got=%b want=0", k, in_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL m1_beat%0d_valid got=%b want=1", k, out_valid); end
            n_vec++; if (res0 !== exp0[k]) begin n_err++; $display("FAIL m1_beat%0d_lane0 got=%h want=%h", k, res0, exp0[k]); end
            n_vec++; if (res1 !== exp1[k]) begin n_err++; $display("FAIL m1_beat%0d_lane1 got=%h want=%h", k, res1, exp1[k]); end
        end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL m1_idle got=%b want=0", busy); end
    endtask

    task automatic test_backpressure();
        wr_w(2'd0, 8'd3);
        wr_w(2'd1, 8'd4);
        out_ready = 1'b0;
        launch(2'd0, 8'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a = {16'd6, 16'd5};
        tick();
        in_a = {16'd1, 16'd1};
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_c%0d_valid got=%b want=1", k, out_valid); end
            n_vec++; if (res0 !== 32'd15) begin n_err++; $display("FAIL bp_c%0d_lane0 got=%h want=%h", k, res0, 32'd15); end
            n_vec++; if (res1 !== 32'd18) begin n_err++; $display("FAIL bp_c%0d_lane1 got=%h want=%h", k, res1, 32'd18); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_c%0d_in_ready got=%b want=0", k, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
        n_vec++; if (res0 !== 32'd4) begin n_err++; $display("FAIL bp_next_lane0 got=%h want=%h", res0, 32'd4); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_accepted got=%b want=0", out_valid); end
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_step();
        launch(2'd2, 8'd1, 1'b1, 1'b1);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = {16'h0001, 16'h1234};
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy got=%b want=0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got=%b want=0", out_valid); end
        n_vec++; if (out_res !== 64'd0) begin n_err++; $display("FAIL mrst_out_res got=%h want=0", out_res); end
        launch(2'd0, 8'd1, 1'b0, 1'b0);
        start = 1'b0;
        in_valid = 1'b1;
        in_a = {16'd2, 16'd1};
        tick();
        in_valid = 1'b0;
        n_vec++; if (res0 !== 32'd3) begin n_err++; $display("FAIL mrst_w_lane0 got=%h want=%h", res0, 32'd3); end
        n_vec++; if (res1 !== 32'd6) begin n_err++; $display("FAIL mrst_w_lane1 got=%h want=%h", res1, 32'd6); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp0 [3];
        exp0[0] = 32'd3; exp0[1] = 32'd4; exp0[2] = 32'd7;
        wr_w(2'd2, 8'd7);
        wr_w(2'd3, 8'hFE);
        // mode 3 and acc_len 0 behave as mode0 and a single beat
        launch(2'd3, 8'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a = {16'd2, 16'd1};
        for (int k = 0; k < 3; k++) begin
            if (k == 2) start = 1'b0;
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_%0d_valid got=%b want=1", k, out_valid); end
            n_vec++; if (res0 !== exp0[k]) begin n_err++; $display("FAIL b2b_%0d_lane0 got=%h want=%h", k, res0, exp0[k]); end
            n_vec++; if (res1 !== (exp0[k] << 1)) begin n_err++; $display("FAIL b2b_%0d_lane1 got=%h want=%h", k, res1, exp0[k] << 1); end
        end
        in_valid = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b want=0", busy); end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        acc_len   = 8'd1;
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = 2'd0;
        w_wr_data = 8'd0;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        out_ready = 1'b1;
        test_reset();
        test_mode0_signed();
        test_mode2_unsigned();
        test_mode2_signed();
        test_mode1_wrap();
        test_backpressure();
        test_reset_mid_step();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
